stack_ctrl: RTL and testbench

Stack controller for the b16 data/return stacks. It owns one 8-entry, 16-bit `stackram` instance and keeps the top-of-stack in a register, so the stack holds up to 9 values. It executes one push, pop or replace per cycle and presents TOS and NOS to the ALU every cycle. It hides the RAM's one-cycle registered read with a write-forwarding register and reports overflow and underflow as sticky flags.

---
 rtl/stack_ctrl_if.sv | 31 +++
 rtl/stack_ctrl.sv | 99 +++++++++
 tb/tb_stack_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/stack_ctrl_if.sv
// Bundles the stack controller's op/result signals and its stackram port.
// master = op source plus RAM model side; slave = the controller.
interface stack_ctrl_if;
    logic [1:0]  op;
    logic [15:0] din;
    logic        clr_err;
    logic [15:0] tos;
    logic [15:0] nos;
    logic [3:0]  depth;
    logic        empty;
    logic        full;
    logic        ovf;
    logic        unf;
    logic [15:0] ram_data;
    logic        ram_wren;
    logic [2:0]  ram_wraddr;
    logic [2:0]  ram_rdaddr;
    logic [15:0] ram_q;

    modport master (
        output op, din, clr_err, ram_q,
        input  tos, nos, depth, empty, full, ovf, unf,
               ram_data, ram_wren, ram_wraddr, ram_rdaddr
    );

    modport slave (
        input  op, din, clr_err, ram_q,
        output tos, nos, depth, empty, full, ovf, unf,
               ram_data, ram_wren, ram_wraddr, ram_rdaddr
    );
endinterface

// File: rtl/stack_ctrl.sv
// 9-deep b16 stack: TOS register over an 8x16 registered-read RAM; one op per cycle,
// results one edge later, no backpressure (ops at depth limits are dropped and flagged).
module stack_ctrl (
    input  logic         clock,
    input  logic         reset_n,
    stack_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_REPL = 2'b11
    } op_e;

    logic [15:0] t_q, t_d;
    logic [15:0] f_q, f_d;
    logic [3:0]  depth_q, depth_d;
    logic        fwd_q, fwd_d;
    logic        ovf_q, ovf_d;
    logic        unf_q, unf_d;
    logic        ovf_evt, unf_evt, wr_c;
    logic [15:0] nos_c;

    // The slot just pushed is read back stale by the RAM, so F stands in until a pop.
    assign nos_c = (depth_q >= 4'd2) ? (fwd_q ? f_q : bus.ram_q) : 16'h0000;

    always_comb begin
        t_d     = t_q;
        f_d     = f_q;
        depth_d = depth_q;
        fwd_d   = fwd_q;
        ovf_evt = 1'b0;
        unf_evt = 1'b0;
        wr_c    = 1'b0;
        case (op_e'(bus.op))
            OP_PUSH: begin
                if (depth_q == 4'd9) begin
                    ovf_evt = 1'b1;
                end else begin
                    if (depth_q != 4'd0) begin
                        wr_c  = 1'b1;
                        f_d   = t_q;
                        fwd_d = 1'b1;
                    end
                    t_d     = bus.din;
                    depth_d = depth_q + 4'd1;
                end
            end
            OP_POP: begin
                if (depth_q == 4'd0) begin
                    unf_evt = 1'b1;
                end else begin
                    t_d     = nos_c;
                    depth_d = depth_q - 4'd1;
                    fwd_d   = 1'b0;
                end
            end
            OP_REPL: begin
                if (depth_q == 4'd0) unf_evt = 1'b1;
                else                 t_d     = bus.din;
            end
            default: ;
        endcase
        // A fresh error outranks a simultaneous clear.
        ovf_d = (ovf_q & ~bus.clr_err) | ovf_evt;
        unf_d = (unf_q & ~bus.clr_err) | unf_evt;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            t_q     <= 16'h0000;
            f_q     <= 16'h0000;
            depth_q <= 4'd0;
            fwd_q   <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            t_q     <= t_d;
            f_q     <= f_d;
            depth_q <= depth_d;
            fwd_q   <= fwd_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign bus.tos        = t_q;
    assign bus.nos        = nos_c;
    assign bus.depth      = depth_q;
    assign bus.empty      = (depth_q == 4'd0);
    assign bus.full       = (depth_q == 4'd9);
    assign bus.ovf        = ovf_q;
    assign bus.unf        = unf_q;
    assign bus.ram_data   = t_q;
    assign bus.ram_wren   = wr_c & reset_n;
    assign bus.ram_wraddr = depth_q[2:0] - 3'd1;
    // Address arithmetic is mod 8; the value is unused whenever next depth < 2.
    assign bus.ram_rdaddr = depth_d[2:0] - 3'd2;
endmodule

// File: tb/tb_stack_ctrl.sv
// Random and directed ops against a queue-based stack model, with a behavioural stackram.
module tb_stack_ctrl;
    logic clock;
    logic reset_n;
    stack_ctrl_if sif();

    stack_ctrl dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (sif.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // stackram: 8x16, registered read returning the pre-write word
    logic [15:0] mem [8];
    always @(posedge clock) begin
        if (sif.ram_wren) mem[sif.ram_wraddr] <= sif.ram_data;
        sif.ram_q <= mem[sif.ram_rdaddr];
    end

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] stk [$];
    bit m_ovf, m_unf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_state();
        int sz;
        sz = stk.size();
        check("tos",   sif.tos,   (sz >= 1) ? stk[sz-1] : 16'h0000);
        check("nos",   sif.nos,   (sz >= 2) ? stk[sz-2] : 16'h0000);
        check("depth", sif.depth, sz);
        check("empty", sif.empty, sz == 0);
        check("full",  sif.full,  sz == 9);
        check("ovf",   sif.ovf,   m_ovf);
        check("unf",   sif.unf,   m_unf);
    endtask

    // Called at a negedge; returns at the following negedge with results checked.
    task automatic do_op(input logic [1:0] o, input logic [15:0] d, input logic c);
        int   sz;
        logic exp_wren;
        sif.op      = o;
        sif.din     = d;
        sif.clr_err = c;
        sz = stk.size();
        #1;
        exp_wren = (o == 2'b01) && (sz >= 1) && (sz < 9);
        check("ram_wren", sif.ram_wren, exp_wren);
        if (exp_wren) begin
            check("ram_wraddr", sif.ram_wraddr, sz - 1);
            check("ram_data",   sif.ram_data,   stk[sz-1]);
        end
        @(posedge clock);
        if (c) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        case (o)
            2'b01: if (sz == 9) m_ovf = 1'b1; else stk.push_back(d);
            2'b10: if (sz == 0) m_unf = 1'b1; else void'(stk.pop_back());
            2'b11: if (sz == 0) m_unf = 1'b1; else stk[sz-1] = d;
            default: ;
        endcase
        @(negedge clock);
        sif.op      = 2'b00;
        sif.clr_err = 1'b0;
        compare_state();
    endtask

    task automatic do_reset(input logic [1:0] o);
        reset_n = 1'b0;
        sif.op  = o;
        sif.din = 16'($urandom);
        @(posedge clock);
        stk.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        sif.op  = 2'b00;
        #1;
        check("rst_wren", sif.ram_wren, 1'b0);
        compare_state();
    endtask

    task automatic drain();
        while (stk.size() > 0) do_op(2'b10, 16'h0000, 1'b0);
    endtask

    initial begin
        reset_n     = 1'b0;
        sif.op      = 2'b00;
        sif.din     = 16'h0000;
        sif.clr_err = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        do_reset(2'b01);

        // single push from empty: no RAM write
        do_op(2'b01, 16'h1111, 1'b0);
        check("tp1_tos", sif.tos, 16'h1111);
        drain();

        // forwarded NOS, then NOS from RAM after pop
        do_op(2'b01, 16'h1111, 1'b0);
        do_op(2'b01, 16'h2222, 1'b0);
        do_op(2'b01, 16'h3333, 1'b0);
        check("tp2_nos_fwd", sif.nos, 16'h2222);
        do_op(2'b10, 16'h0000, 1'b0);
        check("tp2_nos_ram", sif.nos, 16'h1111);
        drain();

        // fill, overflow, empty out
        for (int i = 1; i <= 9; i++) do_op(2'b01, 16'(i), 1'b0);
        check("tp3_full", sif.full, 1'b1);
        do_op(2'b01, 16'hFFFF, 1'b0);
        check("tp3_ovf", sif.ovf, 1'b1);
        check("tp3_tos", sif.tos, 16'h0009);
        for (int i = 0; i < 9; i++) do_op(2'b10, 16'h0000, 1'b0);
        check("tp3_empty", sif.empty, 1'b1);

        // underflow, error-beats-clear, plain clear
        do_op(2'b10, 16'h0000, 1'b0);
        do_op(2'b11, 16'h1234, 1'b0);
        do_op(2'b10, 16'h0000, 1'b1);
        check("tp4_unf_kept", sif.unf, 1'b1);
        do_op(2'b00, 16'h0000, 1'b1);
        check("tp4_unf_clr", sif.unf, 1'b0);

        // replace below a fresh push keeps the forwarded NOS
        do_op(2'b01, 16'hAAAA, 1'b0);
        do_op(2'b01, 16'hBBBB, 1'b0);
        do_op(2'b11, 16'hCCCC, 1'b0);
        check("tp5_nos", sif.nos, 16'hAAAA);
        drain();

        // reset mid-sequence
        for (int i = 0; i < 5; i++) do_op(2'b01, 16'(16'h0100 + i), 1'b0);
        do_reset(2'b10);
        do_op(2'b01, 16'h5A5A, 1'b0);
        check("tp6_tos", sif.tos, 16'h5A5A);

        // random mix
        for (int i = 0; i < 1500; i++) begin
            int          r;
            logic [1:0]  o;
            r = int'($urandom_range(0, 99));
            if      (r < 40) o = 2'b01;
            else if (r < 75) o = 2'b10;
            else if (r < 88) o = 2'b11;
            else             o = 2'b00;
            if ($urandom_range(0, 299) == 0)
                do_reset(2'($urandom_range(0, 3)));
            else
                do_op(o, 16'($urandom), $urandom_range(0, 15) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
